// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, limits and divider helper for the word-oriented
//               UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Largest word the transmitter may be configured for, in bytes
   localparam int UART_MAX_WORD_BYTES = 16;

   // Transmitter states; values 6 and 7 are unused and recover to IDLE
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      GAP    = 3'd5
   } uart_tx_state_t;

   // Rounded clocks-per-bit divider
   function automatic int uart_calc_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Bit-period timer. Counts DIV clocks per bit and pulses tick on
//               the last clock of each bit; restarted by a synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
   parameter int DIV = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int            CNT_W    = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] count;

   // Free-running modulo-DIV counter; wrapping in place keeps bit edges drift-free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == CNT_LAST) ? '0 : count + 1'b1;
      end
   end

   assign tick = enable && !clear && (count == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_word_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_tx
// Description : Serialises a WORD_BYTES-wide word as back-to-back 8-bit UART
//               characters, LSB byte first, with valid/ready handshake,
//               optional parity, 1-2 stop bits, inter-byte gap and a done
//               pulse at the end of the last stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int WORD_BYTES  = 4,
   parameter int PARITY_EN   = 0,
   parameter int PARITY_ODD  = 0,
   parameter int STOP_BITS   = 1,
   parameter int GAP_BITS    = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [8*WORD_BYTES-1:0] data_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    uart_tx_o
);

   localparam int DIV     = uart_calc_div(CLK_FREQ_HZ, BAUD_RATE);
   localparam int SHIFT_W = 8 * WORD_BYTES;
   localparam int IDX_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

   localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(WORD_BYTES - 1);
   localparam logic [3:0]       LAST_DATA = 4'd7;
   localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic [3:0]       LAST_GAP  = 4'(GAP_BITS - 1);
   localparam logic             PAR_INV   = (PARITY_ODD != 0);

   // Reject configurations the datapath cannot represent
   generate
      if (DIV < 2) begin : g_div_check
         $error("uart_word_tx: clock-per-bit divider must be at least 2");
      end
      if (WORD_BYTES < 1 || WORD_BYTES > UART_MAX_WORD_BYTES) begin : g_bytes_check
         $error("uart_word_tx: WORD_BYTES out of range");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
         $error("uart_word_tx: STOP_BITS must be 1 or 2");
      end
      if (GAP_BITS < 0 || GAP_BITS > 15) begin : g_gap_check
         $error("uart_word_tx: GAP_BITS out of range");
      end
   endgenerate

   uart_tx_state_t     state, state_nxt;
   logic [SHIFT_W-1:0] shreg, shreg_nxt;
   logic [3:0]         bit_cnt, bit_cnt_nxt;
   logic [IDX_W-1:0]   byte_idx, byte_idx_nxt;
   logic               parity, parity_nxt;
   logic               line, line_nxt;
   logic               done, done_nxt;
   logic               busy;
   logic               accept;
   logic               tick;

   assign busy   = (state != IDLE);
   assign accept = valid_i && !busy;

   uart_baud_tick #(
      .DIV (DIV)
   ) u_baud_tick (
      .clk    (clk_i),
      .rst    (rst_i),
      .clear  (accept),
      .enable (busy),
      .tick   (tick)
   );

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus next line level; the line is registered so each bit
   // appears on the pin exactly at the tick that enters it
   always_comb begin
      state_nxt    = state;
      shreg_nxt    = shreg;
      bit_cnt_nxt  = bit_cnt;
      byte_idx_nxt = byte_idx;
      parity_nxt   = parity;
      line_nxt     = line;
      done_nxt     = 1'b0;

      case (state)
         IDLE: begin
            line_nxt = 1'b1;
            if (valid_i) begin
               state_nxt    = START;
               shreg_nxt    = data_i;
               bit_cnt_nxt  = '0;
               byte_idx_nxt = '0;
               line_nxt     = 1'b0;
            end
         end

         START: begin
            if (tick) begin
               state_nxt   = DATA;
               line_nxt    = shreg[0];
               bit_cnt_nxt = '0;
               parity_nxt  = (^shreg[7:0]) ^ PAR_INV;
            end
         end

         DATA: begin
            if (tick) begin
               // Shifting after the 8th bit leaves the next byte at the bottom
               shreg_nxt = shreg >> 1;
               if (bit_cnt == LAST_DATA) begin
                  bit_cnt_nxt = '0;
                  if (PARITY_EN != 0) begin
                     state_nxt = PARITY;
                     line_nxt  = parity;
                  end else begin
                     state_nxt = STOP;
                     line_nxt  = 1'b1;
                  end
               end else begin
                  bit_cnt_nxt = bit_cnt + 4'd1;
                  line_nxt    = shreg[1];
               end
            end
         end

         PARITY: begin
            if (tick) begin
               state_nxt   = STOP;
               line_nxt    = 1'b1;
               bit_cnt_nxt = '0;
            end
         end

         STOP: begin
            if (tick) begin
               if (bit_cnt == LAST_STOP) begin
                  bit_cnt_nxt = '0;
                  if (byte_idx == LAST_BYTE) begin
                     state_nxt = IDLE;
                     line_nxt  = 1'b1;
                     done_nxt  = 1'b1;
                  end else begin
                     byte_idx_nxt = byte_idx + 1'b1;
                     if (GAP_BITS != 0) begin
                        state_nxt = GAP;
                        line_nxt  = 1'b1;
                     end else begin
                        state_nxt = START;
                        line_nxt  = 1'b0;
                     end
                  end
               end else begin
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end
            end
         end

         GAP: begin
            if (tick) begin
               if (bit_cnt == LAST_GAP) begin
                  state_nxt   = START;
                  line_nxt    = 1'b0;
                  bit_cnt_nxt = '0;
               end else begin
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            line_nxt  = 1'b1;
         end
      endcase
   end

   // Datapath registers and glitch-free registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         byte_idx <= '0;
         parity   <= 1'b0;
         line     <= 1'b1;
         done     <= 1'b0;
      end else begin
         shreg    <= shreg_nxt;
         bit_cnt  <= bit_cnt_nxt;
         byte_idx <= byte_idx_nxt;
         parity   <= parity_nxt;
         line     <= line_nxt;
         done     <= done_nxt;
      end
   end

   assign ready_o   = !busy;
   assign busy_o    = busy;
   assign done_o    = done;
   assign uart_tx_o = line;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_word_tx
// Description : Self-checking bench for uart_word_tx. Five configurations run
//               side by side; a frame-level model expands each accepted word
//               into its expected line bits and is compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_tx;

   localparam int N    = 5;
   localparam int MAXB = 64;
   localparam int LH   = 20000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]       rst;
   logic [N-1:0]       valid;
   logic [N-1:0][31:0] data;
   logic [N-1:0]       line_w;
   logic [N-1:0]       ready_w;
   logic [N-1:0]       busy_w;
   logic [N-1:0]       done_w;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------------------------------------------------------- DUTs
   uart_word_tx u0 (
      .clk_i(clk), .rst_i(rst[0]), .data_i(data[0]), .valid_i(valid[0]),
      .ready_o(ready_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]), .uart_tx_o(line_w[0]));

   uart_word_tx #(.CLK_FREQ_HZ(10_000), .BAUD_RATE(1000), .WORD_BYTES(1),
                  .PARITY_EN(1), .PARITY_ODD(0)) u1 (
      .clk_i(clk), .rst_i(rst[1]), .data_i(data[1][7:0]), .valid_i(valid[1]),
      .ready_o(ready_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]), .uart_tx_o(line_w[1]));

   uart_word_tx #(.CLK_FREQ_HZ(10_000), .BAUD_RATE(1000), .WORD_BYTES(1),
                  .PARITY_EN(1), .PARITY_ODD(1)) u2 (
      .clk_i(clk), .rst_i(rst[2]), .data_i(data[2][7:0]), .valid_i(valid[2]),
      .ready_o(ready_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]), .uart_tx_o(line_w[2]));

   uart_word_tx #(.CLK_FREQ_HZ(10_000), .BAUD_RATE(1000), .WORD_BYTES(2),
                  .STOP_BITS(2), .GAP_BITS(0)) u3 (
      .clk_i(clk), .rst_i(rst[3]), .data_i(data[3][15:0]), .valid_i(valid[3]),
      .ready_o(ready_w[3]), .busy_o(busy_w[3]), .done_o(done_w[3]), .uart_tx_o(line_w[3]));

   uart_word_tx #(.CLK_FREQ_HZ(5_000), .BAUD_RATE(1000), .WORD_BYTES(2),
                  .GAP_BITS(2)) u4 (
      .clk_i(clk), .rst_i(rst[4]), .data_i(data[4][15:0]), .valid_i(valid[4]),
      .ready_o(ready_w[4]), .busy_o(busy_w[4]), .done_o(done_w[4]), .uart_tx_o(line_w[4]));

   // ------------------------------------------------ per-instance settings
   function automatic int cfg_div(input int m);
      case (m)
         0:       return 434;
         4:       return 5;
         default: return 10;
      endcase
   endfunction

   function automatic int cfg_wb(input int m);
      case (m)
         0:       return 4;
         1, 2:    return 1;
         default: return 2;
      endcase
   endfunction

   function automatic bit cfg_pen(input int m);
      return (m == 1 || m == 2);
   endfunction

   function automatic bit cfg_podd(input int m);
      return (m == 2);
   endfunction

   function automatic int cfg_stop(input int m);
      return (m == 3) ? 2 : 1;
   endfunction

   function automatic int cfg_gap(input int m);
      case (m)
         3:       return 0;
         4:       return 2;
         default: return 1;
      endcase
   endfunction

   // ------------------------------------------------------------- checker
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ----------------------------------------------------- frame-level model
   bit mbits [N][MAXB];
   int mn [N];
   int mk [N];

   // Expand a word into the line level of every bit time of its frame
   task automatic load_frame(input int m, input logic [31:0] d);
      int n;
      logic [7:0] b;
      n = 0;
      for (int k = 0; k < cfg_wb(m); k++) begin
         b = d[8*k +: 8];
         mbits[m][n] = 1'b0; n++;
         for (int i = 0; i < 8; i++) begin
            mbits[m][n] = b[i]; n++;
         end
         if (cfg_pen(m)) begin
            mbits[m][n] = (^b) ^ cfg_podd(m); n++;
         end
         for (int s = 0; s < cfg_stop(m); s++) begin
            mbits[m][n] = 1'b1; n++;
         end
         if (k < cfg_wb(m) - 1) begin
            for (int g = 0; g < cfg_gap(m); g++) begin
               mbits[m][n] = 1'b1; n++;
            end
         end
      end
      mn[m] = n;
   endtask

   int   tot;
   logic e_line, e_ready, e_done;

   // Every cycle: compare all DUTs against the model, then advance the model
   initial begin
      for (int m = 0; m < N; m++) begin
         mk[m] = -1;
         mn[m] = 0;
      end
      forever begin
         @(negedge clk);
         for (int m = 0; m < N; m++) begin
            tot = mn[m] * cfg_div(m);
            if (rst[m] || mk[m] < 0) begin
               e_line = 1'b1; e_ready = 1'b1; e_done = 1'b0;
            end else if (mk[m] < tot) begin
               e_line = mbits[m][mk[m] / cfg_div(m)]; e_ready = 1'b0; e_done = 1'b0;
            end else begin
               e_line = 1'b1; e_ready = 1'b1; e_done = 1'b1;
            end
            chk($sformatf("u%0d_line", m),  32'(line_w[m]),  32'(e_line));
            chk($sformatf("u%0d_ready", m), 32'(ready_w[m]), 32'(e_ready));
            chk($sformatf("u%0d_busy", m),  32'(busy_w[m]),  32'(!e_ready));
            chk($sformatf("u%0d_done", m),  32'(done_w[m]),  32'(e_done));
            if (rst[m]) begin
               mk[m] = -1;
            end else if (e_ready && valid[m]) begin
               load_frame(m, data[m]);
               mk[m] = 0;
            end else if (mk[m] >= 0) begin
               mk[m] = mk[m] + 1;
               if (mk[m] > tot) mk[m] = -1;
            end
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   bit lineh [LH];

   // Decode one character whose start bit begins at bit time start_bit
   function automatic logic [7:0] decode(input int start_bit, input int div);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = lineh[(start_bit + 1 + i) * div + div / 2];
      return r;
   endfunction

   // Send one word, record the line per cycle since accept, check done latency
   task automatic tx_word(input int m, input logic [31:0] d, input bit wiggle, input int exp_len);
      int a;
      bit seen;
      @(posedge clk); #2;
      data[m]  = d;
      valid[m] = 1'b1;
      for (int i = 0; i < 1000 && !ready_w[m]; i++) begin
         @(posedge clk); #2;
      end
      chk($sformatf("u%0d_ready_before_send", m), 32'(ready_w[m]), 32'd1);
      @(posedge clk); #2;
      a        = cyc;
      valid[m] = 1'b0;
      seen     = 1'b0;
      for (int k = 0; k < exp_len + 50 && !seen; k++) begin
         @(negedge clk);
         if (k < LH) lineh[k] = line_w[m];
         if (done_w[m]) begin
            seen = 1'b1;
            chk($sformatf("u%0d_done_latency", m), cyc - a, exp_len);
         end
         #1;
         if (wiggle && k < exp_len - 10) begin
            valid[m] = 1'($urandom_range(0, 1));
            data[m]  = $urandom;
         end else begin
            valid[m] = 1'b0;
         end
      end
      valid[m] = 1'b0;
      if (!seen) chk($sformatf("u%0d_done_seen", m), 32'd0, 32'd1);
   endtask

   int n_acc, n_done, last_acc, n_abort_done;

   initial begin
      rst   = '1;
      valid = '0;
      data  = '0;
      repeat (3) @(posedge clk);

      // Reset state
      @(negedge clk);
      chk("rst_line",  32'(line_w[0]),  32'd1);
      chk("rst_ready", 32'(ready_w[0]), 32'd1);
      chk("rst_busy",  32'(busy_w[0]),  32'd0);
      chk("rst_done",  32'(done_w[0]),  32'd0);
      @(posedge clk); #2;
      rst = '0;

      // Default configuration, valid/data toggled during the frame
      tx_word(0, 32'h44434241, 1'b1, 18662);
      for (int b = 0; b < 4; b++)
         chk($sformatf("u0_byte%0d", b), 32'(decode(b * 11, 434)), 32'(8'h41 + b));
      chk("u0_gap_high",  32'(lineh[10 * 434 + 217]), 32'd1);
      chk("u0_start2_low", 32'(lineh[11 * 434 + 217]), 32'd0);

      // Even and odd parity on 0x07
      tx_word(1, 32'h07, 1'b0, 110);
      chk("u1_byte",        32'(decode(0, 10)), 32'h07);
      chk("u1_parity_even", 32'(lineh[95]),     32'd1);
      chk("u1_stop",        32'(lineh[105]),    32'd1);
      tx_word(2, 32'h07, 1'b0, 110);
      chk("u2_parity_odd",  32'(lineh[95]),     32'd0);

      // Two stop bits, no gap
      tx_word(3, 32'h00FF, 1'b0, 220);
      chk("u3_byte0",      32'(decode(0, 10)),  32'hFF);
      chk("u3_byte1",      32'(decode(11, 10)), 32'h00);
      chk("u3_stop_first", 32'(lineh[90]),      32'd1);
      chk("u3_stop_last",  32'(lineh[109]),     32'd1);
      chk("u3_start2_now", 32'(lineh[110]),     32'd0);

      // Reset during the data bits of the second byte
      @(posedge clk); #2;
      data[3]  = 32'hA55A;
      valid[3] = 1'b1;
      @(posedge clk); #2;
      valid[3] = 1'b0;
      repeat (150) @(posedge clk);
      #3;
      chk("u3_busy_before_rst", 32'(busy_w[3]), 32'd1);
      rst[3] = 1'b1;
      #1;
      chk("u3_async_line",  32'(line_w[3]),  32'd1);
      chk("u3_async_ready", 32'(ready_w[3]), 32'd1);
      repeat (3) @(posedge clk);
      #2;
      rst[3] = 1'b0;
      n_abort_done = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done_w[3]) n_abort_done++;
      end
      chk("u3_no_done_after_abort", n_abort_done, 0);
      tx_word(3, 32'h1234, 1'b0, 220);
      chk("u3_after_rst_byte0", 32'(decode(0, 10)),  32'h34);
      chk("u3_after_rst_byte1", 32'(decode(11, 10)), 32'h12);

      // valid held high with incrementing data
      @(posedge clk); #2;
      valid[4] = 1'b1;
      data[4]  = 32'h0100;
      n_acc    = 0;
      n_done   = 0;
      last_acc = 0;
      for (int i = 0; i < 600 && n_done < 3; i++) begin
         @(negedge clk);
         if (done_w[4]) n_done++;
         if (ready_w[4]) begin
            if (n_acc > 0) chk("u4_accept_on_done", 32'(done_w[4]), 32'd1);
            @(posedge clk); #1;
            if (n_acc > 0) chk("u4_accept_period", cyc - last_acc, 111);
            last_acc = cyc;
            n_acc++;
            @(negedge clk);
            chk("u4_start_next_clock", 32'(line_w[4]), 32'd0);
            #1;
            data[4] = data[4] + 32'h0101;
         end
      end
      valid[4] = 1'b0;
      for (int i = 0; i < 300 && !ready_w[4]; i++) @(negedge clk);
      chk("u4_accept_count", n_acc, 4);
      chk("u4_done_count",   n_done, 3);

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Backstop against a hung run
   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
